pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch program-counter generator for the pipelined core. It replaces the fixed 32-bit PC register with a width-configurable, reset-vector-configurable unit. It arbitrates trap, branch-redirect, prediction and sequential next-PC sources. Redirects that arrive while fetch is stalled (hazard or cache miss) are latched and applied on release, never dropped. It sits at the head of IF and drives the I-cache address and the IF/ID PC field.

## Interface
- XLEN, 32, PC width in bits
- RESET_VEC, 0, value loaded into current_pc on reset (XLEN bits)
- INST_BYTES, 4, sequential increment; power of two; low log2(INST_BYTES) bits of every redirect/pred target forced to 0
- CNT_W, 32, width of the saturating advance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_write  in  1  0 = load-use hazard stall (hold PC)
- cache_stall  in  1  1 = I/D-cache stall (hold PC)
- trap_valid  in  1  exception/ecall redirect request
- trap_pc  in  XLEN  trap target
- redirect_valid  in  1  EX-stage branch/jump mispredict redirect
- redirect_pc  in  XLEN  redirect target
- pred_valid  in  1  predictor hit for current_pc
- pred_pc  in  XLEN  predicted target
- current_pc  out  XLEN  registered fetch PC
- pending_valid  out  1  a latched redirect/trap is waiting for stall release
- advance_count  out  CNT_W  number of edges on which PC advanced (saturating)

## Operation
- stalled = (pc_write == 0) || cache_stall.
- Internal state: current_pc, pend_valid, pend_is_trap, pend_pc, advance_count.
- Non-stalled edge, next current_pc by priority: trap_valid -> trap_pc; else pend_valid && pend_is_trap -> pend_pc; else redirect_valid -> redirect_pc; else pend_valid -> pend_pc; else pred_valid -> pred_pc; else current_pc + INST_BYTES. pend_valid cleared; advance_count += 1 unless at all-ones.
- Stalled edge: current_pc holds. Pending latch update:
  - trap_valid: pend_pc = trap_pc, pend_is_trap = 1, pend_valid = 1 (overwrites any pending).
  - else redirect_valid and not (pend_valid && pend_is_trap): pend_pc = redirect_pc, pend_is_trap = 0, pend_valid = 1.
  - else latch unchanged. pred_valid ignored while stalled. advance_count unchanged.
- Sequential add wraps modulo 2^XLEN (all-ones region + INST_BYTES wraps to low addresses, no flag).
- Alignment: targets masked before use/latching; sequential path keeps alignment by construction.
- pending_valid = pend_valid (registered).

## Timing
- Reset (sync, any cycle incl. mid-stall with pending latched): current_pc = RESET_VEC, pend_valid = 0, pend_is_trap = 0, pend_pc = 0, advance_count = 0, pending_valid = 0. Reset overrides all other inputs on that edge.
- All outputs registered; no combinational input-to-output path.
- Redirect/trap on a non-stalled edge: visible on current_pc the next cycle (1-cycle latency).
- Redirect during stall: visible on current_pc one cycle after the first non-stalled edge; pending_valid rises the cycle after the latching edge and falls the cycle after release.
- Simultaneous release edge with incoming redirect and pending redirect (non-trap): incoming wins, pending discarded.
- Counter saturates at 2^CNT_W - 1; never wraps.

## Test plan
- Reset with RESET_VEC=32'h0000_1000, no stalls, 3 edges -> current_pc 1000, 1004, 1008, 100C; advance_count=3.
- pc_write=0 for 2 edges with redirect_valid=1, redirect_pc=32'h200 on first stalled edge only -> current_pc holds, pending_valid=1; first release edge -> current_pc=200, pending_valid=0.
- Stalled: trap_pc=32'h80 latched, then redirect_pc=32'h300 -> trap retained; release -> current_pc=80.
- Release edge with pending redirect 0x400 and incoming redirect_pc=32'h500 plus pred_valid (pred_pc=0x600) -> current_pc=500.
- redirect_pc=32'h203 with INST_BYTES=4 -> current_pc=200; XLEN=16, current_pc=16'hFFFC sequential -> 16'h0000.
- Reset asserted while cache_stall=1 and pending latched -> RESET_VEC, pending_valid=0; CNT_W=2, 5 advances -> advance_count=3.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Arbitrates trap, branch redirect, prediction and sequential next-PC, and
// latches redirects/traps that arrive while fetch is stalled so they are
// applied on the first non-stalled edge instead of being lost.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int              INST_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             cache_stall,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_pc,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             pred_valid,
  input  logic [XLEN-1:0]  pred_pc,
  output logic [XLEN-1:0]  current_pc,
  output logic             pending_valid,
  output logic [CNT_W-1:0] advance_count
);

  // Targets are forced onto an instruction boundary; the sequential path
  // stays aligned on its own because it always adds INST_BYTES.
  localparam logic [XLEN-1:0]  ALIGN_MASK = ~(XLEN'(INST_BYTES - 1));
  localparam logic [XLEN-1:0]  PC_INC     = XLEN'(INST_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  logic [XLEN-1:0]  r_pc;
  logic             r_pend_valid;
  logic             r_pend_is_trap;
  logic [XLEN-1:0]  r_pend_pc;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN-1:0]  w_pc_next;
  logic             w_pend_valid_next;
  logic             w_pend_is_trap_next;
  logic [XLEN-1:0]  w_pend_pc_next;
  logic [CNT_W-1:0] w_cnt_next;

  logic             w_stalled;
  logic [XLEN-1:0]  w_trap_tgt;
  logic [XLEN-1:0]  w_redirect_tgt;
  logic [XLEN-1:0]  w_pred_tgt;

  assign w_stalled      = !pc_write || cache_stall;
  assign w_trap_tgt     = trap_pc & ALIGN_MASK;
  assign w_redirect_tgt = redirect_pc & ALIGN_MASK;
  assign w_pred_tgt     = pred_pc & ALIGN_MASK;

  // Next-state selection: advance with priority arbitration, or hold and latch.
  always_comb begin
    w_pc_next           = r_pc;
    w_pend_valid_next   = r_pend_valid;
    w_pend_is_trap_next = r_pend_is_trap;
    w_pend_pc_next      = r_pend_pc;
    w_cnt_next          = r_cnt;

    if (!w_stalled) begin
      // A pending trap outranks a fresh redirect; a pending redirect is older
      // than a fresh one, so the fresh redirect wins and the pending is dropped.
      if (trap_valid) begin
        w_pc_next = w_trap_tgt;
      end else if (r_pend_valid && r_pend_is_trap) begin
        w_pc_next = r_pend_pc;
      end else if (redirect_valid) begin
        w_pc_next = w_redirect_tgt;
      end else if (r_pend_valid) begin
        w_pc_next = r_pend_pc;
      end else if (pred_valid) begin
        w_pc_next = w_pred_tgt;
      end else begin
        w_pc_next = r_pc + PC_INC;
      end
      w_pend_valid_next = 1'b0;
      if (r_cnt != CNT_MAX) begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end else begin
      // While stalled a trap always overwrites; a redirect may not displace
      // a latched trap. Predictions are meaningless for a held PC.
      if (trap_valid) begin
        w_pend_pc_next      = w_trap_tgt;
        w_pend_is_trap_next = 1'b1;
        w_pend_valid_next   = 1'b1;
      end else if (redirect_valid && !(r_pend_valid && r_pend_is_trap)) begin
        w_pend_pc_next      = w_redirect_tgt;
        w_pend_is_trap_next = 1'b0;
        w_pend_valid_next   = 1'b1;
      end
    end
  end

  // State registers with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_VEC;
      r_pend_valid   <= 1'b0;
      r_pend_is_trap <= 1'b0;
      r_pend_pc      <= '0;
      r_cnt          <= '0;
    end else begin
      r_pc           <= w_pc_next;
      r_pend_valid   <= w_pend_valid_next;
      r_pend_is_trap <= w_pend_is_trap_next;
      r_pend_pc      <= w_pend_pc_next;
      r_cnt          <= w_cnt_next;
    end
  end

  assign current_pc    = r_pc;
  assign pending_valid = r_pend_valid;
  assign advance_count = r_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the stimulus process pushes the expected
// post-edge state, a monitor on the falling edge pops and compares.
module tb_pc_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: 32-bit PC, reset vector 0x1000
  logic        reset, pc_write, cache_stall;
  logic        trap_valid, redirect_valid, pred_valid;
  logic [31:0] trap_pc, redirect_pc, pred_pc;
  logic [31:0] current_pc;
  logic        pending_valid;
  logic [31:0] advance_count;

  pc_gen #(.XLEN(32), .RESET_VEC(32'h0000_1000), .INST_BYTES(4), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .pc_write(pc_write), .cache_stall(cache_stall),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .current_pc(current_pc), .pending_valid(pending_valid),
    .advance_count(advance_count)
  );

  // Instance 1: 16-bit PC for wrap-around, 2-bit counter for saturation
  logic        reset1;
  logic        pc_write1 = 1'b1;
  logic        zero1 = 1'b0;
  logic [15:0] zero_pc1 = 16'h0;
  logic [15:0] current_pc1;
  logic        pending_valid1;
  logic [1:0]  advance_count1;

  pc_gen #(.XLEN(16), .RESET_VEC(16'hFFF8), .INST_BYTES(4), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset1), .pc_write(pc_write1), .cache_stall(zero1),
    .trap_valid(zero1), .trap_pc(zero_pc1),
    .redirect_valid(zero1), .redirect_pc(zero_pc1),
    .pred_valid(zero1), .pred_pc(zero_pc1),
    .current_pc(current_pc1), .pending_valid(pending_valid1),
    .advance_count(advance_count1)
  );

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] pc;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Wait for one rising edge, then record what the DUT must show afterwards.
  task automatic cyc(input int sel, input string nm, input logic [31:0] epc,
                     input logic ep, input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = sel; e.name = nm; e.pc = epc; e.pend = ep; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the oldest expectation against the DUT outputs.
  initial begin
    exp_t        e;
    logic [31:0] a_pc, a_cnt;
    logic        a_pend;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.sel == 0) begin
          a_pc = current_pc; a_pend = pending_valid; a_cnt = advance_count;
        end else begin
          a_pc = {16'h0, current_pc1}; a_pend = pending_valid1;
          a_cnt = {30'h0, advance_count1};
        end
        n_checks++;
        if (a_pc !== e.pc) begin
          n_errors++;
          $display("FAIL %s current_pc: got %h expected %h", e.name, a_pc, e.pc);
        end
        n_checks++;
        if (a_pend !== e.pend) begin
          n_errors++;
          $display("FAIL %s pending_valid: got %b expected %b", e.name, a_pend, e.pend);
        end
        n_checks++;
        if (a_cnt !== e.cnt) begin
          n_errors++;
          $display("FAIL %s advance_count: got %0d expected %0d", e.name, a_cnt, e.cnt);
        end
        $display("txn %-14s pc=%h pend=%b cnt=%0d", e.name, a_pc, a_pend, a_cnt);
      end
    end
  end

  initial begin
    reset = 1'b1; reset1 = 1'b1;
    pc_write = 1'b1; cache_stall = 1'b0;
    trap_valid = 1'b0; redirect_valid = 1'b0; pred_valid = 1'b0;
    trap_pc = '0; redirect_pc = '0; pred_pc = '0;

    // Reset and plain sequential fetch
    cyc(0, "reset", 32'h1000, 1'b0, 0);
    reset = 1'b0;
    cyc(0, "seq1", 32'h1004, 1'b0, 1);
    cyc(0, "seq2", 32'h1008, 1'b0, 2);
    cyc(0, "seq3", 32'h100C, 1'b0, 3);

    // Redirect latched during a load-use stall, applied on release
    pc_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(0, "stall_latch", 32'h100C, 1'b1, 3);
    redirect_valid = 1'b0;
    cyc(0, "stall_hold", 32'h100C, 1'b1, 3);
    pc_write = 1'b1;
    cyc(0, "release_redir", 32'h200, 1'b0, 4);
    cyc(0, "after_rel", 32'h204, 1'b0, 5);

    // Latched trap is not displaced by a later redirect
    cache_stall = 1'b1; trap_valid = 1'b1; trap_pc = 32'h80;
    cyc(0, "trap_latch", 32'h204, 1'b1, 5);
    trap_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc(0, "trap_keep", 32'h204, 1'b1, 5);
    redirect_valid = 1'b0; cache_stall = 1'b0;
    cyc(0, "trap_release", 32'h80, 1'b0, 6);

    // Prediction with a misaligned target
    pred_valid = 1'b1; pred_pc = 32'h606;
    cyc(0, "pred", 32'h604, 1'b0, 7);
    pred_valid = 1'b0;

    // Incoming redirect beats pending redirect and prediction on release
    pc_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
    cyc(0, "pend_400", 32'h604, 1'b1, 7);
    pc_write = 1'b1; redirect_pc = 32'h500; pred_valid = 1'b1; pred_pc = 32'h600;
    cyc(0, "incoming_wins", 32'h500, 1'b0, 8);
    redirect_valid = 1'b0; pred_valid = 1'b0;
    cyc(0, "pend_dropped", 32'h504, 1'b0, 9);

    // Pending redirect beats prediction on release
    pc_write = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h700;
    cyc(0, "pend_700", 32'h504, 1'b1, 9);
    pc_write = 1'b1; redirect_valid = 1'b0; pred_valid = 1'b1; pred_pc = 32'h900;
    cyc(0, "pend_over_pred", 32'h700, 1'b0, 10);
    pred_valid = 1'b0;

    // Misaligned redirect target is masked
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    cyc(0, "redir_align", 32'h200, 1'b0, 11);
    redirect_valid = 1'b0;

    // Prediction ignored while stalled
    cache_stall = 1'b1; pred_valid = 1'b1; pred_pc = 32'hA00;
    cyc(0, "pred_stalled", 32'h200, 1'b0, 11);
    cache_stall = 1'b0; pred_valid = 1'b0;
    cyc(0, "seq_after", 32'h204, 1'b0, 12);

    // Trap beats simultaneous redirect, misaligned trap target masked
    trap_valid = 1'b1; trap_pc = 32'h83; redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc(0, "trap_direct", 32'h80, 1'b0, 13);
    trap_valid = 1'b0;

    // Reset while stalled with a redirect pending
    cache_stall = 1'b1; redirect_pc = 32'h444;
    cyc(0, "pend_444", 32'h80, 1'b1, 13);
    reset = 1'b1; trap_valid = 1'b1;
    cyc(0, "reset_stall", 32'h1000, 1'b0, 0);
    reset = 1'b0; trap_valid = 1'b0; redirect_valid = 1'b0; cache_stall = 1'b0;
    cyc(0, "post_reset", 32'h1004, 1'b0, 1);

    // 16-bit wrap-around and 2-bit counter saturation
    cyc(1, "x16_reset", 32'hFFF8, 1'b0, 0);
    reset1 = 1'b0;
    cyc(1, "x16_seq1", 32'hFFFC, 1'b0, 1);
    cyc(1, "x16_wrap", 32'h0000, 1'b0, 2);
    cyc(1, "x16_seq3", 32'h0004, 1'b0, 3);
    cyc(1, "x16_sat4", 32'h0008, 1'b0, 3);
    cyc(1, "x16_sat5", 32'h000C, 1'b0, 3);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
